rcb_frl_training_pattern_gen: RTL and testbench

//  Parametrised training-pattern source for the Fast Radio Link TX lane.
//  - On a START request, emits a counted burst of alternating PAT_A/PAT_B words (or PRBS7, optional).
//  - Signals completion with DONE; supports ABORT.
//  - Sits ahead of the FRL serializer mux; the RX side uses the burst for bit/word alignment.

---
 rtl/rcb_frl_training_pattern_gen.sv | 186 ++++++++++++++++++
 tb/tb_rcb_frl_training_pattern_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rcb_frl_training_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : rcb_frl_training_pattern_gen
// Description : Training-pattern source for the Fast Radio Link TX lane.
//               On an accepted start request it emits a counted (or
//               continuous) burst of alternating PAT_A/PAT_B words, one per
//               cycle, then pulses done. Abort terminates the burst at once
//               without a done pulse.
//               Optional feature macro FRL_TRAIN_PRBS_EN adds a mode input
//               selecting a PRBS7 (x^7+x^6+1) word stream instead.
// Revision    : 1.0 - initial release
// ============================================================================
module rcb_frl_training_pattern_gen #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] PAT_A  = DATA_W'(8'hF4),
    parameter logic [DATA_W-1:0] PAT_B  = DATA_W'(8'hC2),
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  train_len,
`ifdef FRL_TRAIN_PRBS_EN
    input  logic              mode,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_TRAIN = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nx;

    // Down-counter of words still to emit, including the one on data_out.
    // A value of zero marks a continuous burst and is never decremented.
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;

    // 1 = the next alternating word to emit is PAT_B.
    logic                phase;
    logic                phase_nx;

    logic [DATA_W-1:0]   data_nx;
    logic                valid_nx;
    logic                done_nx;

    // Word source selection; tied off when the PRBS feature is absent.
    logic                start_prbs;
    logic                run_prbs;
    logic [DATA_W-1:0]   prbs_word;

`ifdef FRL_TRAIN_PRBS_EN
    logic                mode_q;
    logic                mode_nx;
    logic [6:0]          lfsr;
    logic [6:0]          lfsr_nx;
    logic [6:0]          prbs_src;
    logic [6:0]          prbs_after;
    logic [6:0]          prbs_tmp;
    logic                prbs_bit;

    assign start_prbs = mode;
    assign run_prbs   = mode_q;

    // A fresh burst always starts from the all-ones seed; otherwise continue
    // from the running LFSR state.
    assign prbs_src   = (state == ST_IDLE) ? 7'h7F : lfsr;

    // Advance the LFSR DATA_W steps; first generated bit lands in the MSB.
    always_comb begin
        prbs_tmp  = prbs_src;
        prbs_bit  = 1'b0;
        prbs_word = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            prbs_bit     = prbs_tmp[6] ^ prbs_tmp[5];
            prbs_tmp     = {prbs_tmp[5:0], prbs_bit};
            prbs_word[i] = prbs_bit;
        end
        prbs_after = prbs_tmp;
    end

    // LFSR and latched mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr   <= '0;
            mode_q <= 1'b0;
        end else begin
            lfsr   <= lfsr_nx;
            mode_q <= mode_nx;
        end
    end
`else
    assign start_prbs = 1'b0;
    assign run_prbs   = 1'b0;
    assign prbs_word  = '0;
`endif

    // Next-state and next-output decode; outputs are registered so the first
    // word appears on the same edge that accepts start.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        phase_nx = phase;
        data_nx  = '0;
        valid_nx = 1'b0;
        done_nx  = 1'b0;
`ifdef FRL_TRAIN_PRBS_EN
        lfsr_nx  = lfsr;
        mode_nx  = mode_q;
`endif
        case (state)
            ST_IDLE: begin
                // Abort has priority: a simultaneous start is dropped.
                if (start && !abort) begin
                    state_nx = ST_TRAIN;
                    cnt_nx   = train_len;
                    phase_nx = 1'b1;
                    valid_nx = 1'b1;
                    data_nx  = start_prbs ? prbs_word : PAT_A;
`ifdef FRL_TRAIN_PRBS_EN
                    mode_nx  = mode;
                    lfsr_nx  = prbs_after;
`endif
                end
            end
            ST_TRAIN: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    phase_nx = 1'b0;
                end else if (cnt == CNT_W'(1)) begin
                    // Last counted word is currently on the output.
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    phase_nx = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    valid_nx = 1'b1;
                    phase_nx = ~phase;
                    data_nx  = run_prbs ? prbs_word : (phase ? PAT_B : PAT_A);
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
`ifdef FRL_TRAIN_PRBS_EN
                    lfsr_nx  = prbs_after;
`endif
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                phase_nx = 1'b0;
            end
        endcase
    end

    // State, counter, phase and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            phase      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            phase      <= phase_nx;
            data_out   <= data_nx;
            data_valid <= valid_nx;
            done       <= done_nx;
        end
    end

    assign busy = (state == ST_TRAIN);

endmodule
`default_nettype wire

// File: tb/tb_rcb_frl_training_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rcb_frl_training_pattern_gen
// Description : Self-checking bench for rcb_frl_training_pattern_gen in the
//               alternating-pattern build. A word-index model predicts the
//               outputs every cycle; directed sequences add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rcb_frl_training_pattern_gen;

    localparam int         DATA_W = 8;
    localparam int         CNT_W  = 16;
    localparam logic [7:0] PA     = 8'hF4;
    localparam logic [7:0] PB     = 8'hC2;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic              abort     = 1'b0;
    logic [CNT_W-1:0]  train_len = '0;
`ifdef FRL_TRAIN_PRBS_EN
    logic              mode      = 1'b0;
`endif
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic              done;

    int n_vec = 0;
    int n_err = 0;

    rcb_frl_training_pattern_gen #(
        .DATA_W (DATA_W),
        .PAT_A  (PA),
        .PAT_B  (PB),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .train_len  (train_len),
`ifdef FRL_TRAIN_PRBS_EN
        .mode       (mode),
`endif
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Model: a burst is "active" while emitting word number idx (0-based)
    // out of len words; len == 0 means endless.
    bit m_active = 1'b0;
    int m_idx    = 0;
    int m_len    = 0;
    bit m_done   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_idx    = 0;
            m_len    = 0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (start && !abort) begin
                    m_active = 1'b1;
                    m_len    = int'(train_len);
                    m_idx    = 0;
                end
            end else if (abort) begin
                m_active = 1'b0;
            end else if (m_len != 0 && m_idx == m_len - 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end else begin
                m_idx = m_idx + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_data",  32'(data_out),
                m_active ? ((m_idx % 2 == 0) ? 32'(PA) : 32'(PB)) : 32'h0);
            chk("model_valid", 32'(data_valid), 32'(m_active));
            chk("model_busy",  32'(busy),       32'(m_active));
            chk("model_done",  32'(done),       32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [7:0] d, input logic v,
                       input logic b, input logic dn);
        chk({nm, "_data"},  32'(data_out),   32'(d));
        chk({nm, "_valid"}, 32'(data_valid), 32'(v));
        chk({nm, "_busy"},  32'(busy),       32'(b));
        chk({nm, "_done"},  32'(done),       32'(dn));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        lit("idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Counted burst of 5
        train_len = 16'd5; start = 1'b1;
        tick(); start = 1'b0;
        lit("len5_w1", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("len5_w2", PB, 1'b1, 1'b1, 1'b0);
        tick(); lit("len5_w3", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("len5_w4", PB, 1'b1, 1'b1, 1'b0);
        tick(); lit("len5_w5", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("len5_done", 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); lit("len5_after", 8'h00, 1'b0, 1'b0, 1'b0);

        // Continuous burst, abort after 1000 words
        train_len = 16'd0; start = 1'b1;
        tick(); start = 1'b0;
        lit("cont_w1", PA, 1'b1, 1'b1, 1'b0);
        repeat (998) tick();
        lit("cont_w999", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("cont_w1000", PB, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick(); abort = 1'b0;
        lit("cont_abort", 8'h00, 1'b0, 1'b0, 1'b0);
        tick(); lit("cont_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Abort on the last word of LEN=3, then immediate restart
        train_len = 16'd3; start = 1'b1;
        tick(); start = 1'b0;
        lit("ab3_w1", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("ab3_w2", PB, 1'b1, 1'b1, 1'b0);
        tick(); lit("ab3_w3", PA, 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick(); abort = 1'b0;
        lit("ab3_nodone", 8'h00, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick(); start = 1'b0;
        lit("ab3_restart", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("ab3_r2", PB, 1'b1, 1'b1, 1'b0);
        tick(); lit("ab3_r3", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("ab3_rdone", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();

        // Start held high through LEN=2 bursts
        train_len = 16'd2; start = 1'b1;
        tick(); lit("hold_w1", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("hold_w2", PB, 1'b1, 1'b1, 1'b0);
        tick(); lit("hold_gap", 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); lit("hold_b2w1", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("hold_b2w2", PB, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        tick(); lit("hold_done2", 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); lit("hold_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Start together with abort in idle is dropped
        train_len = 16'd4; start = 1'b1; abort = 1'b1;
        tick(); start = 1'b0; abort = 1'b0;
        lit("st_ab", 8'h00, 1'b0, 1'b0, 1'b0);
        tick(); lit("st_ab_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Length change during a burst has no effect
        train_len = 16'd2; start = 1'b1;
        tick(); start = 1'b0; train_len = 16'd7;
        lit("lenchg_w1", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("lenchg_w2", PB, 1'b1, 1'b1, 1'b0);
        tick(); lit("lenchg_done", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();

        // LEN=1 boundary
        train_len = 16'd1; start = 1'b1;
        tick(); start = 1'b0;
        lit("len1_w1", PA, 1'b1, 1'b1, 1'b0);
        tick(); lit("len1_done", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();

        // Asynchronous reset mid-burst, between clock edges
        train_len = 16'd4; start = 1'b1;
        tick(); start = 1'b0;
        tick(); lit("rst_pre", PB, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 lit("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        tick(); lit("rst_nodone1", 8'h00, 1'b0, 1'b0, 1'b0);
        tick(); lit("rst_nodone2", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
